// File: rtl/nro_fibbinario_if.sv
// Signal bundle for the fibbinary detector: four value bits in, registered
// flag, sequence index and saturating hit count out.
interface nro_fibbinario_if #(
  parameter int unsigned CNT_W = 8
);
  logic             A;
  logic             B;
  logic             C;
  logic             D;
  logic             F;
  logic [2:0]       fib_index;
  logic [CNT_W-1:0] fib_count;

  modport master (
    output A, B, C, D,
    input  F, fib_index, fib_count
  );

  modport slave (
    input  A, B, C, D,
    output F, fib_index, fib_count
  );
endinterface

// File: rtl/nro_fibbinario.sv
// Registered fibbinary detector: flags 4-bit values with no adjacent 1s,
// reports their rank in the fibbinary sequence and counts hits (saturating).
module nro_fibbinario #(
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  nro_fibbinario_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]       v;
  logic             fib;
  logic [2:0]       idx;

  logic             f_q;
  logic [2:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;

  // Index is the Zeckendorf value of the bit pattern (weights 5,3,2,1).
  always_comb begin
    v   = {bus.A, bus.B, bus.C, bus.D};
    fib = ~(bus.A & bus.B) & ~(bus.B & bus.C) & ~(bus.C & bus.D);
    // NOTE: default assigned first so every path drives idx and no latch is inferred.
    idx = 3'd0;
    case (v)
      4'b0000: idx = 3'd0;
      4'b0001: idx = 3'd1;
      4'b0010: idx = 3'd2;
      4'b0100: idx = 3'd3;
      4'b0101: idx = 3'd4;
      4'b1000: idx = 3'd5;
      4'b1001: idx = 3'd6;
      4'b1010: idx = 3'd7;
      default: idx = 3'd0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_q   <= 1'b0;
      idx_q <= 3'd0;
      cnt_q <= '0;
    end else begin
      f_q   <= fib;
      idx_q <= idx;
      if (fib && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.F         = f_q;
  assign bus.fib_index = idx_q;
  assign bus.fib_count = cnt_q;

endmodule

// File: tb/tb_nro_fibbinario.sv
// Self-checking bench for nro_fibbinario: directed steps plus random vectors,
// run on an 8-bit and a 2-bit counter instance against a behavioural model.
module tb_nro_fibbinario;

  logic clk;
  logic reset;

  nro_fibbinario_if #(.CNT_W(8)) bus8 ();
  nro_fibbinario_if #(.CNT_W(2)) bus2 ();

  nro_fibbinario #(.CNT_W(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));
  nro_fibbinario #(.CNT_W(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_err;

  // Reference state
  int ref_f;
  int ref_idx;
  int ref_cnt8;
  int ref_cnt2;

  function automatic bit is_fib(input int v);
    return ((v & (v >> 1)) == 0);
  endfunction

  // Rank of v among fibbinary numbers: how many fibbinary values lie below it.
  function automatic int fib_rank(input int v);
    int r;
    r = 0;
    if (!is_fib(v)) return 0;
    for (int k = 0; k < v; k++) begin
      if (is_fib(k)) r++;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int v, input bit rst);
    bus8.A = v[3]; bus8.B = v[2]; bus8.C = v[1]; bus8.D = v[0];
    bus2.A = v[3]; bus2.B = v[2]; bus2.C = v[1]; bus2.D = v[0];
    reset  = rst;
  endtask

  // One clock: drive, update model, then compare both instances.
  task automatic step(input int v, input bit rst, input string tag);
    drive(v, rst);
    @(posedge clk);
    #1;
    if (rst) begin
      ref_f = 0; ref_idx = 0; ref_cnt8 = 0; ref_cnt2 = 0;
    end else begin
      ref_f   = is_fib(v) ? 1 : 0;
      ref_idx = fib_rank(v);
      if (ref_f == 1 && ref_cnt8 < 255) ref_cnt8++;
      if (ref_f == 1 && ref_cnt2 < 3)   ref_cnt2++;
    end
    check({tag, ".F"},     {31'd0, bus8.F},         ref_f);
    check({tag, ".idx"},   {29'd0, bus8.fib_index}, ref_idx);
    check({tag, ".cnt8"},  {24'd0, bus8.fib_count}, ref_cnt8);
    check({tag, ".F2"},    {31'd0, bus2.F},         ref_f);
    check({tag, ".idx2"},  {29'd0, bus2.fib_index}, ref_idx);
    check({tag, ".cnt2"},  {30'd0, bus2.fib_count}, ref_cnt2);
  endtask

  initial begin
    int v;
    n_vec = 0;
    n_err = 0;
    ref_f = 0; ref_idx = 0; ref_cnt8 = 0; ref_cnt2 = 0;
    drive(0, 1'b1);

    // Reset for two cycles, then basic transitions from the test plan.
    step(0, 1'b1, "rst0");
    step(0, 1'b1, "rst1");
    step(4'b0000, 1'b0, "v0");
    step(4'b0100, 1'b0, "v4");
    step(4'b1111, 1'b0, "v15");
    step(4'b1001, 1'b0, "v9");

    // Reset takes priority over a fibbinary sample and does not count it.
    step(4'b0101, 1'b1, "rst_prio");

    // Full sweep; the 8-bit count ends at 8.
    for (int i = 0; i < 16; i++) step(i, 1'b0, "sweep");
    check("sweep_total", {24'd0, bus8.fib_count}, 32'd8);

    // Saturation of the 2-bit counter with v=0101, then reset clears all.
    step(0, 1'b1, "rst_sat");
    for (int i = 0; i < 6; i++) step(4'b0101, 1'b0, "hold5");
    check("sat2_value", {30'd0, bus2.fib_count}, 32'd3);
    step(4'b0101, 1'b1, "rst_after_sat");

    // Saturation of the 8-bit counter.
    for (int i = 0; i < 260; i++) step(4'b1010, 1'b0, "sat8");
    check("sat8_value", {24'd0, bus8.fib_count}, 32'd255);

    // Mid-operation reset followed by resumed counting.
    step(4'b0001, 1'b1, "rst_mid");
    step(4'b0001, 1'b0, "resume");

    // Random vectors with occasional reset.
    for (int i = 0; i < 400; i++) begin
      v = int'($urandom_range(0, 15));
      step(v, ($urandom_range(0, 31) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nro_fibbinario.md
Name: nro_fibbinario

Overview:
- Registered fibbinary-number detector for a 4-bit value presented on four single-bit inputs A (MSB), B, C, D (LSB).
- A 4-bit value is fibbinary when its binary form has no two adjacent 1s. The 4-bit fibbinary set is {0, 1, 2, 4, 5, 8, 9, 10}.
- Per clock, the block flags fibbinary inputs and reports the value's index in the fibbinary sequence.
- It also keeps a saturating count of detected fibbinary samples. It serves as a small classification leaf in the digital-systems lab datapath.

Parameters:
- CNT_W, default 8: width of the saturating hit counter fib_count. Legal range is 1 to 16.

Ports:
- clk  input  1  rising-edge clock; all state updates on this edge
- reset  input  1  synchronous, active-high reset
- A  input  1  value bit 3 (MSB)
- B  input  1  value bit 2
- C  input  1  value bit 1
- D  input  1  value bit 0 (LSB)
- F  output  1  registered flag; 1 when the sampled value is fibbinary
- fib_index  output  3  registered index of the sampled value in the ascending fibbinary sequence; 0 when not fibbinary
- fib_count  output  CNT_W  registered saturating count of cycles in which the sampled value was fibbinary

Behaviour:
- Value formation: v = {A,B,C,D}, where A is the MSB.
- Combinational classification: fib = ~(A&B) & ~(B&C) & ~(C&D).
- fib is 1 for v = 0, 1, 2, 4, 5, 8, 9, 10.
- fib is 0 for v = 3, 6, 7, 11, 12, 13, 14, 15.
- Index map (v -> fib_index): 0->0, 1->1, 2->2, 4->3, 5->4, 8->5, 9->6, 10->7. Every non-fibbinary v maps to index 0.
- This map is the Zeckendorf mapping, i.e. fib_index = n when v is the Zeckendorf bit pattern of n.
- Registering: on each rising clk with reset=0:
  - F <= fib
  - fib_index <= index(v)
  - fib_count <= fib_count + 1 when fib=1 and fib_count is below its maximum; otherwise fib_count holds.
- Latency: one cycle. Inputs sampled at edge k appear on the outputs after edge k and remain stable until edge k+1.
- There is no combinational path from the inputs to the outputs.
- Saturation: fib_count stops at 2^CNT_W − 1 and never wraps.
- Reset: when reset=1 at a rising edge, the next register values are F=0, fib_index=0 and fib_count=0.
  - Reset has priority over the sampled inputs on that edge.
  - A sample taken on a reset edge is not counted.
- Reset mid-operation: the count clears and counting resumes from 0 on the first non-reset edge.
- Power-up values before the first reset are undefined; the bench must apply reset first.
- Input changes between clock edges have no effect until the next rising edge.
- Each input bit is treated independently, so any single-bit or multi-bit change in one cycle is simply reclassified.

Test Plan:
- Reset for 2 cycles with ABCD=0000, release, hold 1 cycle -> after the first non-reset edge F=1, fib_index=0, fib_count=1.
- Set B=1 (v=0100) -> next edge F=1, fib_index=3, fib_count increments by 1.
- From v=0100, set A=C=D=1 (v=1111) -> next edge F=0, fib_index=0, fib_count holds.
- From v=1111, clear B and C (v=1001) -> next edge F=1, fib_index=6, fib_count increments.
- Sweep v=0..15 one per cycle after reset -> F=1 exactly for 0,1,2,4,5,8,9,10 with indices 0..7 in order; fib_count=8 at the end.
- With CNT_W=2, hold v=0101 for 6 cycles -> fib_count reaches 3 and stays at 3. Then assert reset for one edge -> all outputs 0.
